// File: rtl/dbus_sram_bridge.sv
// Commit-stage data-bus bridge: one-entry request slot, in-order tag FIFO,
// and flush-aware response filtering toward the SRAM-like data bus.
module dbus_sram_bridge #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [1:0]    cpu_size,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic          cpu_addr_ok,
    output logic          cpu_data_ok,
    output logic [31:0]   cpu_rdata,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [31:0]   bus_addr,
    output logic [31:0]   bus_wdata,
    output logic [3:0]    bus_wstrb,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [31:0]   bus_rdata,
    output logic [CW-1:0] outstanding,
    output logic          busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             slot_v_q;
    logic             slot_wr_q;
    logic [1:0]       slot_size_q;
    logic [31:0]      slot_addr_q;
    logic [31:0]      slot_wdata_q;
    logic [3:0]       slot_wstrb_q;
    logic             slot_kill_q;

    logic [DEPTH-1:0] tag_wr_q;
    logic [DEPTH-1:0] tag_kill_q;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic slot_fire;
    logic pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus_req   = slot_v_q & (cnt_q < CW'(DEPTH));
    assign slot_fire = bus_req & bus_addr_ok;
    assign pop       = bus_data_ok & (cnt_q != '0);

    assign bus_wr    = slot_wr_q;
    assign bus_size  = slot_size_q;
    assign bus_addr  = slot_addr_q;
    assign bus_wdata = slot_wdata_q;
    assign bus_wstrb = slot_wstrb_q;

    // reset gates addr_ok so a request presented during reset is never acked
    assign cpu_addr_ok = cpu_req & ~flush & ~reset & (~slot_v_q | slot_fire);
    assign cpu_data_ok = pop & ~tag_kill_q[rptr_q];
    assign cpu_rdata   = cpu_data_ok ? bus_rdata : 32'h0;

    assign outstanding = cnt_q;
    assign busy        = slot_v_q | (cnt_q != '0);

    always_comb begin
        wptr_d = slot_fire ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (slot_fire && !pop) cnt_d = cnt_q + 1'b1;
        else if (!slot_fire && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v_q     <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_size_q  <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_wstrb_q <= '0;
            slot_kill_q  <= 1'b0;
        end else if (cpu_addr_ok) begin
            slot_v_q     <= 1'b1;
            slot_wr_q    <= cpu_wr;
            slot_size_q  <= cpu_size;
            slot_addr_q  <= cpu_addr;
            slot_wdata_q <= cpu_wdata;
            slot_wstrb_q <= cpu_wstrb;
            slot_kill_q  <= 1'b0;
        end else begin
            if (slot_fire) slot_v_q <= 1'b0;
            if (flush && slot_v_q) slot_kill_q <= 1'b1;
        end
    end

    // killing free entries is harmless: a push always rewrites its own bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_wr_q   <= '0;
            tag_kill_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (flush) tag_kill_q <= '1;
            if (slot_fire) begin
                tag_wr_q[wptr_q]   <= slot_wr_q;
                tag_kill_q[wptr_q] <= slot_kill_q | flush;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// Randomized bench for dbus_sram_bridge against a transaction-level model.
module tb_dbus_sram_bridge;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, flush;
    logic          cpu_req, cpu_wr;
    logic [1:0]    cpu_size;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic [3:0]    cpu_wstrb;
    logic          cpu_addr_ok, cpu_data_ok;
    logic [31:0]   cpu_rdata;
    logic          bus_req, bus_wr;
    logic [1:0]    bus_size;
    logic [31:0]   bus_addr, bus_wdata;
    logic [3:0]    bus_wstrb;
    logic          bus_addr_ok, bus_data_ok;
    logic [31:0]   bus_rdata;
    logic [CW-1:0] outstanding;
    logic          busy;

    dbus_sram_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
        .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata),
        .outstanding(outstanding), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  wstrb;
        bit        kill;
        bit [31:0] rdata;
    } txn_t;

    // pend: every accepted, unanswered cpu request, oldest first
    txn_t        pend[$];
    logic [31:0] bq[$];
    logic [31:0] ref_mem[16];
    logic [31:0] bus_mem[16];
    int          inflight;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        cpu_size = '0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".bus_req"}, bus_req, 0);
        chk({tag, ".addr_ok"}, cpu_addr_ok, 0);
        chk({tag, ".data_ok"}, cpu_data_ok, 0);
        chk({tag, ".rdata"}, cpu_rdata, 0);
        chk({tag, ".outst"}, outstanding, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        bit          slot_v, e_req, e_fire, e_aok, e_pop, e_dok;
        bit          s_wr;
        logic [31:0] s_addr, s_wdata, e_rd;
        logic [3:0]  s_wstrb;
        int          pct, idx;
        txn_t        t;

        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        #2;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // single load, bus answers one cycle then two cycles later
        cpu_req = 1'b1; cpu_addr = 32'h8000_0010;
        #2;
        chk("c0.addr_ok", cpu_addr_ok, 1);
        chk("c0.bus_req", bus_req, 0);
        @(negedge clk);
        cpu_req = 1'b0; bus_addr_ok = 1'b1;
        #2;
        chk("c1.bus_req", bus_req, 1);
        chk("c1.bus_addr", bus_addr, 32'h8000_0010);
        chk("c1.bus_wr", bus_wr, 0);
        chk("c1.outst", outstanding, 0);
        @(negedge clk);
        bus_addr_ok = 1'b0;
        #2;
        chk("c2.outst", outstanding, 1);
        chk("c2.bus_req", bus_req, 0);
        chk("c2.busy", busy, 1);
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #2;
        chk("c3.data_ok", cpu_data_ok, 1);
        chk("c3.rdata", cpu_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        bus_data_ok = 1'b0;
        #2;
        chk("c4.outst", outstanding, 0);
        chk("c4.busy", busy, 0);
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        #2;
        chk("spur.data_ok", cpu_data_ok, 0);
        chk("spur.rdata", cpu_rdata, 0);
        @(negedge clk);
        bus_data_ok = 1'b0;
        #2;
        chk("spur.outst", outstanding, 0);

        inflight = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            pct = ((cyc / 200) % 3 == 0) ? 10 : (((cyc / 200) % 3 == 1) ? 50 : 90);
            reset       = ($urandom_range(0, 399) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            cpu_req     = ($urandom_range(0, 3) != 0);
            cpu_wr      = $urandom_range(0, 1);
            cpu_size    = 2'($urandom_range(0, 2));
            cpu_addr    = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            cpu_wdata   = $urandom;
            cpu_wstrb   = 4'($urandom);
            bus_addr_ok = ($urandom_range(0, 2) != 0);
            bus_data_ok = ($urandom_range(0, 99) < pct);
            bus_rdata   = (bus_data_ok && bq.size() > 0) ? bq[0] : $urandom;
            #2;
            if (reset) begin
                chk_zero("rnd.reset");
                @(posedge clk);
                pend.delete();
                bq.delete();
                inflight = 0;
                for (int i = 0; i < 16; i++) ref_mem[i] = bus_mem[i];
                continue;
            end
            slot_v = (pend.size() > inflight);
            e_req  = slot_v && (inflight < DEPTH);
            e_fire = e_req && bus_addr_ok;
            e_aok  = cpu_req && !flush && (!slot_v || e_fire);
            e_pop  = bus_data_ok && (inflight > 0);
            e_dok  = e_pop && !pend[0].kill;
            e_rd   = 32'h0;
            if (e_dok) e_rd = pend[0].wr ? bus_rdata : pend[0].rdata;
            chk("bus_req", bus_req, e_req);
            chk("addr_ok", cpu_addr_ok, e_aok);
            chk("data_ok", cpu_data_ok, e_dok);
            chk("rdata", cpu_rdata, e_rd);
            chk("outst", outstanding, inflight);
            chk("busy", busy, pend.size() > 0);
            if (e_req) begin
                t = pend[inflight];
                chk("bus_wr", bus_wr, t.wr);
                chk("bus_size", bus_size, t.size);
                chk("bus_addr", bus_addr, t.addr);
                chk("bus_wdata", bus_wdata, t.wdata);
                chk("bus_wstrb", bus_wstrb, t.wstrb);
            end
            s_wr = bus_wr; s_addr = bus_addr;
            s_wdata = bus_wdata; s_wstrb = bus_wstrb;
            @(posedge clk);
            if (e_fire) begin
                idx = int'(s_addr[5:2]);
                if (s_wr) begin
                    bus_mem[idx] = merge(bus_mem[idx], s_wdata, s_wstrb);
                    bq.push_back($urandom);
                end else begin
                    bq.push_back(bus_mem[idx]);
                end
                inflight++;
            end
            if (e_pop) begin
                void'(pend.pop_front());
                void'(bq.pop_front());
                inflight--;
            end
            if (flush)
                foreach (pend[i]) pend[i].kill = 1'b1;
            if (e_aok) begin
                idx = int'(cpu_addr[5:2]);
                t.wr = cpu_wr; t.size = cpu_size; t.addr = cpu_addr;
                t.wdata = cpu_wdata; t.wstrb = cpu_wstrb; t.kill = 1'b0;
                t.rdata = ref_mem[idx];
                if (cpu_wr) ref_mem[idx] = merge(ref_mem[idx], cpu_wdata, cpu_wstrb);
                pend.push_back(t);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dbus_sram_bridge.md
# dbus_sram_bridge

Data-bus bridge sitting directly downstream of the commit stage's memory port. It accepts the commit stage's load/store requests on the dbus request/response handshake, registers each request in a one-entry request slot, and replays it on an SRAM-like data bus. It tracks up to DEPTH outstanding bus transactions in an in-order tag FIFO and returns read data to commit. A pipeline flush never cancels a bus transaction; it only suppresses the `data_ok` responses of transactions that are already in flight.

## Interface
Parameters:
- DEPTH, 2, maximum accepted-but-unanswered bus transactions; a power of two, ≥1
- CW, $clog2(DEPTH+1), width of `outstanding`

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  kill the responses of every in-flight or slotted transaction
- cpu_req  in  1  commit request valid
- cpu_wr  in  1  1 = store, 0 = load
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  32  physical byte address
- cpu_wdata  in  32  store data
- cpu_wstrb  in  4  byte write enables
- cpu_addr_ok  out  1  request captured this cycle
- cpu_data_ok  out  1  response for the oldest live transaction
- cpu_rdata  out  32  load data, valid with `cpu_data_ok`
- bus_req  out  1  SRAM bus request
- bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb  out  1/2/32/32/4  request fields, held stable while `bus_req` is high
- bus_addr_ok  in  1  bus accepted the request
- bus_data_ok  in  1  bus completed the oldest transaction
- bus_rdata  in  32  bus read data
- outstanding  out  CW  number of accepted, unanswered bus transactions
- busy  out  1  slot valid or `outstanding` ≠ 0

## Operation
- Request slot: registers `{wr, size, addr, wdata, wstrb, kill}` plus a valid bit.
  - slot_fire = `bus_req & bus_addr_ok`.
  - `cpu_addr_ok` = `cpu_req & ~flush & (~slot_valid | slot_fire)`.
  - On `cpu_addr_ok` the slot loads the cpu fields with kill = 0.
  - Else, on slot_fire, the slot becomes invalid.
- `bus_req` = `slot_valid & (outstanding < DEPTH)`. It is registered-path only, with no combinational dependence on `bus_data_ok`.
  - All `bus_*` fields come directly from the slot.
  - Once `bus_req` is raised, the fields do not change until slot_fire.
- Tag FIFO: DEPTH entries of `{wr, kill}`, with read/write pointers modulo DEPTH.
  - slot_fire pushes `{slot.wr, slot.kill | flush}`.
  - `bus_data_ok` with `outstanding` > 0 pops the head.
- Response path:
  - `cpu_data_ok` = `bus_data_ok & (outstanding ≠ 0) & ~head.kill`.
  - `cpu_rdata` = `bus_rdata` when `cpu_data_ok`, else 0.
  - Stores produce `cpu_data_ok` like loads; `cpu_rdata` is don't-care for stores but driven from `bus_rdata`.
- flush:
  - Sets kill on every valid FIFO entry and on the slot if it is valid.
  - Does not deassert `bus_req` and does not clear the slot. The killed transaction still issues and completes on the bus, and its `bus_data_ok` is swallowed.
  - If a pop and a flush occur in the same cycle, the popping head's own kill bit decides its `cpu_data_ok`; flush does not affect it.
- outstanding: +1 on slot_fire, −1 on a valid pop, unchanged when both occur.
- Protocol error: `bus_data_ok` while `outstanding` = 0 is ignored. No pop, no `cpu_data_ok`, and the counter stays at 0.

## Timing
- Reset: asynchronous. `bus_req`, `cpu_addr_ok`, `cpu_data_ok`, `outstanding` and `busy` are 0, `cpu_rdata` is 0, the slot is invalid and the FIFO pointers are 0.
  - Reset mid-transaction drops all state; late `bus_data_ok` after reset is handled by the protocol-error rule.
- Request latency:
  - `cpu_addr_ok` in cycle N gives `bus_req` = 1 from cycle N+1, provided `outstanding` < DEPTH.
  - `bus_addr_ok` in cycle N+1 allows a new cpu request to be captured in that same cycle, so the sustained rate is one request per cycle.
- Response latency: `cpu_data_ok` is combinational with `bus_data_ok` (0 cycles).
- Full: at `outstanding` = DEPTH, `bus_req` = 0. The slot holds, and `cpu_addr_ok` = 0 while the slot is valid.
- Ordering: responses return strictly in acceptance order, and no transaction is ever reordered.

## Test plan
- Single load at 0x8000_0010, bus answers `bus_addr_ok` next cycle and `bus_data_ok` 2 cycles later with 0xDEADBEEF:
  - `cpu_addr_ok` at cycle 0, `bus_req` at cycle 1, `cpu_data_ok` with `cpu_rdata` = 0xDEADBEEF at cycle 3.
  - `outstanding` goes 0→1→0 and `busy` returns to 0.
- Back-to-back: 4 stores with `bus_addr_ok` tied high and DEPTH = 2, `bus_data_ok` withheld:
  - Exactly 2 `bus_req` accepts; `outstanding` = 2; `bus_req` = 0; the third request sits in the slot; `cpu_addr_ok` = 0 for the fourth.
  - Releasing `bus_data_ok` drains all 4 in order.
- Flush with 2 in flight plus a slotted request:
  - The next 3 `bus_data_ok` give `cpu_data_ok` = 0, and the slotted request still reaches the bus with its original addr and wdata.
  - A new request after the flush returns `cpu_data_ok` = 1.
- Same-cycle slot_fire, pop and new `cpu_req` at `outstanding` = 1: `outstanding` stays 1, the new request is captured, and `cpu_data_ok` = 1.
- Spurious `bus_data_ok` when idle: no `cpu_data_ok`, and `outstanding` stays 0.
- `reset` asserted while `outstanding` = 2 and the slot is valid: all outputs are 0 immediately; after release a fresh load completes normally.
